serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - bit-serial a - b, LSB first, one full-subtractor cell and a borrow flop
// Results are registered and only change on the edge that enters DONE.
module serial_subtractor #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, r_sh_q, r_sh_d, diff_q;
  logic [CW-1:0]    cnt_q;
  logic             bor_q, bor_d, d_bit, last_bit;
  logic             a_msb_q, b_msb_q, borrow_q, ovf_q;

  always_comb begin
    d_bit    = a_sh_q[0] ^ b_sh_q[0] ^ bor_q;
    bor_d    = (~a_sh_q[0] & b_sh_q[0]) | (~(a_sh_q[0] ^ b_sh_q[0]) & bor_q);
    r_sh_d   = {d_bit, r_sh_q[WIDTH-1:1]};
    last_bit = (cnt_q == CW'(WIDTH - 1));
    state_d  = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_bit) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      r_sh_q   <= '0;
      cnt_q    <= '0;
      bor_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            r_sh_q  <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            a_msb_q <= a[WIDTH-1];
            b_msb_q <= b[WIDTH-1];
          end
        end
        S_RUN: begin
          a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
          b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
          r_sh_q <= r_sh_d;
          cnt_q  <= cnt_q + CW'(1);
          bor_q  <= bor_d;
          // d_bit on the last edge is the result MSB
          if (last_bit) begin
            diff_q   <= r_sh_d;
            borrow_q <= bor_d;
            ovf_q    <= (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign diff   = diff_q;
  assign borrow = borrow_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - random + directed scoreboard bench for serial_subtractor
// Driver pushes expected results; a negedge monitor pops them on done and checks holding otherwise.
module tb_serial_subtractor;

  localparam int W    = 6;
  localparam int MASK = (1 << W) - 1;
  localparam int HALF = 1 << (W - 1);

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done, borrow, ovf;
  logic [W-1:0] diff;

  int checks = 0;
  int failures = 0;

  logic [W+1:0] sb_q[$];
  logic [W+1:0] last_res = '0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [W+1:0] model(input int av, input int bv);
    int d, sa, sb, sd;
    logic bo, ov;
    d  = (av - bv) & MASK;
    bo = (av < bv);
    sa = (av >= HALF) ? av - (1 << W) : av;
    sb = (bv >= HALF) ? bv - (1 << W) : bv;
    sd = sa - sb;
    ov = (sd > HALF - 1) || (sd < -HALF);
    return {d[W-1:0], bo, ov};
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      last_res = '0;
    end else begin
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          last_res = sb_q.pop_front();
          check("diff",   int'(diff),   int'(last_res[W+1:2]));
          check("borrow", int'(borrow), int'(last_res[1]));
          check("ovf",    int'(ovf),    int'(last_res[0]));
        end
      end else begin
        check("hold", int'({diff, borrow, ovf}), int'(last_res));
      end
      if (busy && done) check("busy_and_done", 1, 0);
    end
  end

  // Call in an IDLE cycle just after a negedge; returns in the IDLE cycle after DONE.
  task automatic do_op(input int av, input int bv, input bit spur);
    start = 1'b1;
    a = W'(av);
    b = W'(bv);
    sb_q.push_back(model(av, bv));
    @(negedge clk);
    for (int c = 1; c <= W + 1; c++) begin
      if (c <= W) begin
        check("busy_run", int'(busy), 1);
        check("done_run", int'(done), 0);
      end else begin
        check("done_cyc", int'(done), 1);
        check("busy_done", int'(busy), 0);
      end
      if (spur) begin
        start = 1'($urandom);
        a = W'($urandom);
        b = W'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("idle_busy", int'(busy), 0);
    check("idle_done", int'(done), 0);
  endtask

  task automatic abort_op(input int av, input int bv, input int at_cycle);
    start = 1'b1;
    a = W'(av);
    b = W'(bv);
    sb_q.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c < at_cycle; c++) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_busy",   int'(busy),   0);
    check("rst_done",   int'(done),   0);
    check("rst_diff",   int'(diff),   0);
    check("rst_borrow", int'(borrow), 0);
    check("rst_ovf",    int'(ovf),    0);
    void'(sb_q.pop_back());
    @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1;
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_res",  int'({diff, borrow, ovf}), 0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
    @(negedge clk);

    do_op(13, 5, 1'b0);
    do_op(5, 13, 1'b0);
    do_op(32, 1, 1'b0);
    do_op(31, 63, 1'b0);
    do_op(0, 0, 1'b0);
    do_op(63, 63, 1'b0);
    do_op(0, 1, 1'b0);
    do_op(20, 7, 1'b1);
    repeat (3) @(negedge clk);
    abort_op(40, 9, 3);
    do_op(40, 9, 1'b0);

    for (int i = 0; i < 60; i++) begin
      do_op(int'($urandom_range(0, MASK)), int'($urandom_range(0, MASK)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
